// File: rtl/stereolbm_mul_rr_arbiter_if.sv
// stereolbm_mul_rr_arbiter_if: operand request and tagged result channels of the shared multiplier
interface stereolbm_mul_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int OP_W    = 16
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    res_valid;
  logic [2*OP_W-1:0]       res_data;
  logic [ID_W-1:0]         res_id;
  logic                    res_ready;
  logic [31:0]             op_count;
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, op_count
  );
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, op_count
  );
endinterface

// File: rtl/stereolbm_mul_rr_arbiter.sv
// stereolbm_mul_rr_arbiter: round-robin sharing of one unsigned multiplier with a registered tagged result
module stereolbm_mul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int OP_W    = 16
) (
  input logic ap_clk,
  input logic ap_rst,
  stereolbm_mul_rr_arbiter_if.slave bus
);
  logic                r_res_valid;
  logic [2*OP_W-1:0]   r_res_data;
  logic [ID_W-1:0]     r_res_id;
  logic [ID_W-1:0]     r_ptr;
  logic [31:0]         r_op_count;
  logic                w_found;
  logic [ID_W-1:0]     w_gidx;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_can_acc;
  logic                w_acc;
  logic [OP_W-1:0]     w_a;
  logic [OP_W-1:0]     w_b;
  logic [2*OP_W-1:0]   w_prod;

  // first valid requester at or after the priority pointer, wrapping around
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    w_gidx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && bus.req_valid[ID_W'(j)]) begin
        w_found = 1'b1;
        w_gidx = ID_W'(j);
      end
    end
  end

  assign w_grant       = NUM_REQ'(w_found) << w_gidx;
  assign w_can_acc     = !r_res_valid || bus.res_ready;
  assign w_acc         = w_found && w_can_acc && !ap_rst;
  assign bus.req_ready = w_acc ? w_grant : '0;
  assign w_a           = bus.req_a[w_gidx*OP_W +: OP_W];
  assign w_b           = bus.req_b[w_gidx*OP_W +: OP_W];
  assign w_prod        = {{OP_W{1'b0}}, w_a} * {{OP_W{1'b0}}, w_b};

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign bus.op_count  = r_op_count;

  // result register: a new product overwrites a draining one, a stalled one holds
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_ptr       <= '0;
      r_op_count  <= '0;
    end else if (w_acc) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_prod;
      r_res_id    <= w_gidx;
      r_ptr       <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
      r_op_count  <= r_op_count + 32'd1;
    end else if (r_res_valid && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stereolbm_mul_rr_arbiter.sv
// tb_stereolbm_mul_rr_arbiter: randomized and directed scoreboard bench for the shared multiplier arbiter
module tb_stereolbm_mul_rr_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int OPW = 16;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  id;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stereolbm_mul_rr_arbiter_if #(.NUM_REQ(N), .ID_W(IDW), .OP_W(OPW)) bus ();
  stereolbm_mul_rr_arbiter #(.NUM_REQ(N), .ID_W(IDW), .OP_W(OPW)) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  res_t sb[$];
  logic [15:0] op_a [N];
  logic [15:0] op_b [N];
  int last_g;
  int acc_g;
  logic mdl_valid;
  logic [31:0] mdl_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // monitor: every result the downstream takes must match the oldest expected product
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) chk("res_unexpected", 64'd1, 64'd0);
      else begin
        res_t e;
        e = sb.pop_front();
        chk("res_data", 64'(bus.res_data), 64'(e.d));
        chk("res_id", 64'(bus.res_id), 64'(e.id));
      end
    end
  end

  task automatic drive(input logic [3:0] v, input logic rr);
    bus.req_valid = v;
    bus.res_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*OPW +: OPW] = op_a[i];
      bus.req_b[i*OPW +: OPW] = op_b[i];
    end
  endtask

  task automatic step(input logic [3:0] v, input logic rr);
    int g;
    logic [3:0] exp_rdy;
    rst = 1'b0;
    drive(v, rr);
    #2;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (last_g + 1 + k) % N;
      if (g < 0 && v[j]) g = j;
    end
    if (!(!mdl_valid || rr)) g = -1;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("res_valid", 64'(bus.res_valid), 64'(mdl_valid));
    chk("op_count", 64'(bus.op_count), 64'(mdl_cnt));
    acc_g = g;
    if (g >= 0) begin
      res_t e;
      e.d = 32'(op_a[g]) * 32'(op_b[g]);
      e.id = 2'(g);
      sb.push_back(e);
      last_g = g;
      mdl_cnt++;
      mdl_valid = 1'b1;
    end else if (mdl_valid && rr) mdl_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      rst = 1'b1;
      drive(4'b1111, 1'($urandom_range(0, 1)));
      #2;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    sb.delete();
    last_g = N - 1;
    mdl_valid = 1'b0;
    mdl_cnt = '0;
  endtask

  initial begin
    logic [31:0] held_d;
    logic [1:0] held_id;
    logic [3:0] pend;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 16'(i + 1);
      op_b[i] = 16'd10;
    end
    drive(4'b1111, 1'b1);
    @(posedge clk);
    #1;
    do_reset(2);
    step(4'b1111, 1'b1);
    chk("first_grant_id", 64'(bus.res_id), 64'd0);
    step(4'b0000, 1'b1);

    do_reset(1);
    op_a[2] = 16'hFFFF;
    op_b[2] = 16'hFFFF;
    step(4'b0100, 1'b1);
    chk("single_data", 64'(bus.res_data), 64'h0000_0000_FFFE_0001);
    chk("single_id", 64'(bus.res_id), 64'd2);
    chk("single_cnt", 64'(bus.op_count), 64'd1);
    step(4'b0000, 1'b1);

    do_reset(1);
    op_a[2] = 16'd3;
    op_b[2] = 16'd10;
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b1);
    chk("rr_cnt", 64'(bus.op_count), 64'd8);
    chk("rr_last_data", 64'(bus.res_data), 64'd40);

    held_d = bus.res_data;
    held_id = bus.res_id;
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b0);
      chk("stall_data", 64'(bus.res_data), 64'(held_d));
      chk("stall_id", 64'(bus.res_id), 64'(held_id));
    end
    step(4'b0010, 1'b1);
    chk("bp_new_id", 64'(bus.res_id), 64'd1);
    chk("bp_new_data", 64'(bus.res_data), 64'd20);

    step(4'b0001, 1'b1);
    chk("sparse_id0", 64'(bus.res_id), 64'd0);
    step(4'b1010, 1'b1);
    chk("sparse_id1", 64'(bus.res_id), 64'd1);

    step(4'b0100, 1'b1);
    step(4'b0000, 1'b0);
    do_reset(1);
    step(4'b0000, 1'b0);
    step(4'b1111, 1'b1);
    chk("post_rst_id", 64'(bus.res_id), 64'd0);
    step(4'b0000, 1'b1);

    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op_a[i] = 16'($urandom);
          op_b[i] = 16'($urandom);
        end
      end
      step(pend, 1'($urandom_range(0, 3) != 0));
      if (acc_g >= 0) pend[acc_g] = 1'b0;
    end
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stereolbm_mul_rr_arbiter.md
Name: stereolbm_mul_rr_arbiter

Overview:
- Shares one unsigned 16x16->32 multiplier among NUM_REQ requesters, e.g. the SAD/cost units of the stereo block-matching core.
- Each requester has a valid/ready operand port. The block grants one requester per cycle, round-robin.
- It drives the shared combinational multiplier, registers the product, and returns it on a single tagged result channel with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must satisfy 2^ID_W >= NUM_REQ.
- OP_W, 16, operand width; product width is 2*OP_W.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*OP_W  operand A, flattened; requester i occupies bits [i*OP_W +: OP_W].
- req_b  in  NUM_REQ*OP_W  operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; requester i's operands are consumed on a cycle where req_valid[i] && req_ready[i].
- res_valid  out  1  result register holds a product.
- res_data  out  2*OP_W  unsigned product a*b.
- res_id  out  ID_W  index of the requester that issued the product.
- res_ready  in  1  downstream accepts the result.
- op_count  out  32  total accepted operations since reset; wraps modulo 2^32.

Behaviour:
- Reset, while ap_rst=1 at a clock edge:
  - res_valid=0, res_data=0, res_id=0, op_count=0.
  - Priority pointer ptr=0.
  - req_ready is forced to 0 combinationally while ap_rst is high.
- Accept condition: can_acc = !res_valid || res_ready.
  - When can_acc=0, req_ready is all zeros.
- Grant, combinational:
  - Scan indices ptr, ptr+1, ..., ptr+NUM_REQ-1 (mod NUM_REQ).
  - The first index g with req_valid[g]=1 gets req_ready[g]=1, provided can_acc=1.
  - At most one bit of req_ready is high. req_ready never depends on req_a or req_b.
- Multiplier datapath:
  - Operands of the granted requester are muxed into the shared unsigned OP_W x OP_W multiplier.
  - The multiplier is zero-extended, combinational, and gives the full 2*OP_W result with no truncation.
- On an accept edge (some grant active):
  - res_data <= a*b; res_id <= g; res_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
  - op_count <= op_count+1.
- Latency: one cycle. Operands accepted at edge k appear with res_valid=1 immediately after edge k.
- Drain: if res_valid && res_ready and there is no grant, then res_valid <= 0.
- Simultaneous drain and accept:
  - The register is overwritten with the new product in the same edge.
  - This gives full throughput of one op per cycle when res_ready=1.
- Stall: while res_valid && !res_ready, res_data, res_id and res_valid hold stable, and ptr does not move.
- No request: ptr holds. It advances only on a grant.
- Fairness: with all requesters continuously valid and res_ready=1, grants rotate 0,1,...,NUM_REQ-1,0,...
- Starvation: each continuously-valid requester is granted within NUM_REQ accepts.
- Reset mid-operation: any held result is discarded (res_valid=0 next cycle). No grant is issued during the reset cycle.
- Requester inputs while req_ready=0 are ignored. The requester must hold its operands until it is granted; the arbiter does not check this.

Test Plan:
- Reset: assert ap_rst for 2 cycles with req_valid=4'b1111 -> req_ready=0 throughout; after release, res_valid=0, op_count=0, and the first grant goes to requester 0.
- Single op: req 2 presents a=16'hFFFF, b=16'hFFFF for one accept, res_ready=1 -> next cycle res_valid=1, res_data=32'hFFFE0001, res_id=2, op_count=1.
- Round-robin: all four requesters valid continuously with a=i+1, b=10, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3, res_data 10,20,30,40 repeating, op_count=8.
- Backpressure: res_ready=0 for 3 cycles while a result is held with req 1 valid -> req_ready=0, res_data/res_id stable, ptr unchanged. Raise res_ready -> req 1 is granted in that same cycle and its product replaces the held one on the next edge.
- Sparse requests: ptr=2 (last grant was 1), only req 0 valid -> req 0 granted, and ptr becomes 1. Then req 1 and req 3 both valid -> req 1 granted first.
- Reset mid-stall: result held with res_ready=0, assert ap_rst for 1 cycle -> res_valid=0, op_count=0, ptr=0 on the following cycle.
